// File: rtl/interval_timer_if.sv
// Control and status bundle for interval_timer: per-channel strobes, load values and status.
interface interval_timer_if #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned CHANNELS = 2
);
  logic [CHANNELS-1:0]       start;
  logic [CHANNELS-1:0]       stop;
  logic [CHANNELS-1:0]       periodic;
  logic [CHANNELS*CNT_W-1:0] load;
  logic                      base_tick;
  logic [CHANNELS-1:0]       expire;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS*CNT_W-1:0] remaining;

  modport master (
    output start, stop, periodic, load,
    input  base_tick, expire, busy, remaining
  );

  modport slave (
    input  start, stop, periodic, load,
    output base_tick, expire, busy, remaining
  );
endinterface

// File: rtl/interval_timer.sv
// Multi-channel interval timer: shared prescaler base tick feeding one-shot/periodic down-counters.
// Optional TIMER_PAUSE_EN adds a pause input that freezes the prescaler and all channel counts.
module interval_timer #(
  parameter int unsigned CLK_DIV  = 50_000_000,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned CHANNELS = 2
) (
  input  logic clock,
  input  logic clear,
`ifdef TIMER_PAUSE_EN
  input  logic pause,
`endif
  interval_timer_if.slave bus
);

  localparam int unsigned PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [PS_W-1:0] prescale;
  logic            hold;
  logic            tick;

  state_t             state_q [CHANNELS];
  state_t             state_d [CHANNELS];
  logic [CNT_W-1:0]   ld_q    [CHANNELS];
  logic [CNT_W-1:0]   ld_d    [CHANNELS];
  logic [CNT_W-1:0]   rem_q   [CHANNELS];
  logic [CNT_W-1:0]   rem_d   [CHANNELS];
  logic [CHANNELS-1:0] pm_q, pm_d;
  logic [CHANNELS-1:0] exp_q, exp_d;

`ifdef TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Base tick is decoded straight from the free-running prescaler register.
  assign tick = (prescale == '0) && !hold;

  always_ff @(posedge clock) begin
    if (!clear) begin
      prescale <= PS_MAX;
    end else if (!hold) begin
      prescale <= (prescale == '0) ? PS_MAX : prescale - PS_W'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        ld_q[i]    <= '0;
        rem_q[i]   <= '0;
      end
      pm_q  <= '0;
      exp_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        ld_q[i]    <= ld_d[i];
        rem_q[i]   <= rem_d[i];
      end
      pm_q  <= pm_d;
      exp_q <= exp_d;
    end
  end

  // Next-state logic; stop beats start, start beats the base tick.
  always_comb begin
    pm_d  = pm_q;
    exp_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      ld_d[i]    = ld_q[i];
      rem_d[i]   = rem_q[i];

      if (bus.stop[i]) begin
        state_d[i] = IDLE;
        rem_d[i]   = '0;
      end else if (bus.start[i]) begin
        if (bus.load[i*CNT_W +: CNT_W] != '0) begin
          state_d[i] = RUN;
          ld_d[i]    = bus.load[i*CNT_W +: CNT_W];
          pm_d[i]    = bus.periodic[i];
          rem_d[i]   = bus.load[i*CNT_W +: CNT_W];
        end else begin
          state_d[i] = IDLE;
          rem_d[i]   = '0;
        end
      end else if (state_q[i] == RUN && tick) begin
        if (rem_q[i] <= CNT_W'(1)) begin
          exp_d[i] = 1'b1;
          if (pm_q[i]) begin
            rem_d[i] = ld_q[i];
          end else begin
            rem_d[i]   = '0;
            state_d[i] = IDLE;
          end
        end else begin
          rem_d[i] = rem_q[i] - CNT_W'(1);
        end
      end
    end
  end

  assign bus.base_tick = tick;
  assign bus.expire    = exp_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign bus.busy[g]                       = (state_q[g] == RUN);
    assign bus.remaining[g*CNT_W +: CNT_W]   = rem_q[g];
  end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: tick-count reference model plus directed literal checks.
module tb_interval_timer;
  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CHANNELS = 2;

  logic clock = 1'b0;
  logic clear = 1'b0;
  logic pause = 1'b0;

  interval_timer_if #(.CNT_W(CNT_W), .CHANNELS(CHANNELS)) bus ();

  interval_timer #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W), .CHANNELS(CHANNELS)) dut (
    .clock (clock),
    .clear (clear),
`ifdef TIMER_PAUSE_EN
    .pause (pause),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0d, required %0d", name, cyc, act, req);
  endtask

  // Reference model: channels described by start tick count and elapsed base ticks.
  int          cyc = 0;
  bit          model_valid = 1'b0;
  int unsigned act_cnt = 0;
  int unsigned tcount = 0;
  bit          m_on  [CHANNELS];
  bit          m_per [CHANNELS];
  bit          m_exp [CHANNELS];
  int unsigned m_l   [CHANNELS];
  int unsigned m_t0  [CHANNELS];

  function automatic int unsigned exp_rem(input int c);
    int unsigned k;
    k = tcount - m_t0[c];
    if (!m_on[c])      return 0;
    else if (m_per[c]) return m_l[c] - (k % m_l[c]);
    else               return m_l[c] - k;
  endfunction

  always @(posedge clock) begin
    if (!clear) begin
      cyc = 0;
      act_cnt = 0;
      tcount = 0;
      model_valid = 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        m_on[c]  = 1'b0;
        m_exp[c] = 1'b0;
      end
    end else begin
      bit tk;
      tk = !pause && (act_cnt % CLK_DIV == CLK_DIV - 1);
      if (!pause) act_cnt++;
      if (tk) tcount++;
      cyc++;
      for (int c = 0; c < CHANNELS; c++) begin
        int unsigned ld;
        int unsigned k;
        ld = 32'(bus.load[c*CNT_W +: CNT_W]);
        m_exp[c] = 1'b0;
        if (bus.stop[c]) begin
          m_on[c] = 1'b0;
        end else if (bus.start[c]) begin
          m_on[c]  = (ld != 0);
          m_l[c]   = ld;
          m_per[c] = bus.periodic[c];
          m_t0[c]  = tcount;
        end else if (m_on[c] && tk) begin
          k = tcount - m_t0[c];
          if (m_per[c]) begin
            if (k % m_l[c] == 0) m_exp[c] = 1'b1;
          end else if (k == m_l[c]) begin
            m_exp[c] = 1'b1;
            m_on[c]  = 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    logic [CHANNELS-1:0]       eb;
    logic [CHANNELS-1:0]       ee;
    logic [CHANNELS*CNT_W-1:0] er;
    if (model_valid) begin
      for (int c = 0; c < CHANNELS; c++) begin
        eb[c] = m_on[c];
        ee[c] = m_exp[c];
        er[c*CNT_W +: CNT_W] = CNT_W'(exp_rem(c));
      end
      check("model base_tick", 32'(bus.base_tick),
            32'(!pause && (act_cnt % CLK_DIV == CLK_DIV - 1)));
      check("model expire",    32'(bus.expire),    32'(ee));
      check("model busy",      32'(bus.busy),      32'(eb));
      check("model remaining", 32'(bus.remaining), 32'(er));
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 1000) begin
      cycle();
      guard++;
    end
    check("reach cycle", 32'(cyc), 32'(target));
  endtask

  task automatic do_reset();
    clear = 1'b0;
    cycle();
    cycle();
    clear = 1'b1;
  endtask

  task automatic set_load(input int c, input int unsigned v);
    bus.load[c*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  function automatic int unsigned rem(input int c);
    return 32'(bus.remaining[c*CNT_W +: CNT_W]);
  endfunction

  initial begin
    int times[$];
    int n_exp;
    int first_exp;
    bus.start    = '0;
    bus.stop     = '0;
    bus.periodic = '0;
    bus.load     = '0;

    // Idle prescaler after reset release.
    do_reset();
    check("reset busy",      32'(bus.busy),      0);
    check("reset remaining", 32'(bus.remaining), 0);
    check("reset expire",    32'(bus.expire),    0);
    check("reset base_tick", 32'(bus.base_tick), 0);
    goto(3);  check("tick c3", 32'(bus.base_tick), 1);
    goto(4);  check("no tick c4", 32'(bus.base_tick), 0);
    goto(7);  check("tick c7", 32'(bus.base_tick), 1);
    goto(11); check("tick c11", 32'(bus.base_tick), 1);
    check("idle busy", 32'(bus.busy), 0);

    // One-shot, load 3, started in cycle 0.
    do_reset();
    set_load(0, 3);
    bus.periodic[0] = 1'b0;
    bus.start[0] = 1'b1;
    cycle();
    bus.start[0] = 1'b0;
    check("os rem c1", rem(0), 3);
    check("os busy c1", 32'(bus.busy[0]), 1);
    goto(4);  check("os rem c4", rem(0), 2);
    goto(8);  check("os rem c8", rem(0), 1);
    goto(11); check("os no expire c11", 32'(bus.expire[0]), 0);
    goto(12);
    check("os expire c12", 32'(bus.expire[0]), 1);
    check("os busy c12", 32'(bus.busy[0]), 0);
    check("os rem c12", rem(0), 0);
    n_exp = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (bus.expire[0]) n_exp++;
    end
    check("os single pulse", 32'(n_exp), 0);

    // Periodic ch1, load 2; load changed mid-run without restart.
    do_reset();
    set_load(1, 2);
    bus.periodic[1] = 1'b1;
    bus.start[1] = 1'b1;
    cycle();
    bus.start[1] = 1'b0;
    check("per rem c1", rem(1), 2);
    for (int i = 0; i < 33; i++) begin
      if (bus.expire[1]) times.push_back(cyc);
      if (cyc == 9) check("per reload c9", rem(1), 2);
      if (cyc == 10) set_load(1, 7);
      cycle();
    end
    check("per pulse count", 32'(times.size()), 4);
    if (times.size() > 0) check("per first expire", 32'(times[0]), 8);
    for (int j = 1; j < times.size(); j++) check("per period", 32'(times[j] - times[j-1]), 8);
    bus.stop[1] = 1'b1;
    cycle();
    bus.stop[1] = 1'b0;
    check("per stop busy", 32'(bus.busy[1]), 0);
    check("per stop rem", rem(1), 0);

    // Zero load and start+stop together both leave the channel idle.
    set_load(0, 0);
    bus.start[0] = 1'b1;
    cycle();
    bus.start[0] = 1'b0;
    check("zero load busy", 32'(bus.busy[0]), 0);
    set_load(0, 5);
    bus.start[0] = 1'b1;
    bus.stop[0]  = 1'b1;
    cycle();
    bus.start[0] = 1'b0;
    bus.stop[0]  = 1'b0;
    check("start+stop busy", 32'(bus.busy[0]), 0);
    check("start+stop rem", rem(0), 0);
    n_exp = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (bus.expire != '0) n_exp++;
    end
    check("no stray expire", 32'(n_exp), 0);

    // Restart and stop on the terminal tick, then reset mid-run.
    do_reset();
    set_load(0, 2);
    bus.periodic[0] = 1'b0;
    bus.start[0] = 1'b1;
    cycle();
    bus.start[0] = 1'b0;
    goto(4); check("term rem c4", rem(0), 1);
    goto(7);
    check("term tick c7", 32'(bus.base_tick), 1);
    set_load(0, 4);
    bus.start[0] = 1'b1;
    cycle();
    bus.start[0] = 1'b0;
    check("restart no expire", 32'(bus.expire[0]), 0);
    check("restart rem", rem(0), 4);
    check("restart busy", 32'(bus.busy[0]), 1);
    goto(20); check("term rem c20", rem(0), 1);
    goto(23);
    check("term tick c23", 32'(bus.base_tick), 1);
    bus.stop[0] = 1'b1;
    cycle();
    bus.stop[0] = 1'b0;
    check("stop no expire", 32'(bus.expire[0]), 0);
    check("stop busy", 32'(bus.busy[0]), 0);
    set_load(0, 3);
    set_load(1, 9);
    bus.start = 2'b11;
    cycle();
    bus.start = 2'b00;
    check("both busy", 32'(bus.busy), 3);
    goto(26);
    clear = 1'b0;
    cycle();
    check("midrun reset busy",      32'(bus.busy),      0);
    check("midrun reset remaining", 32'(bus.remaining), 0);
    check("midrun reset expire",    32'(bus.expire),    0);
    check("midrun reset base_tick", 32'(bus.base_tick), 0);
    clear = 1'b1;

`ifdef TIMER_PAUSE_EN
    // Ten paused cycles mid-interval push the expire out by ten cycles.
    do_reset();
    set_load(0, 3);
    bus.periodic[0] = 1'b0;
    bus.start[0] = 1'b1;
    cycle();
    bus.start[0] = 1'b0;
    goto(5);
    pause = 1'b1;
    goto(6);  check("pause rem c6", rem(0), 2);
    goto(7);  check("pause no tick c7", 32'(bus.base_tick), 0);
    goto(12); check("pause no expire c12", 32'(bus.expire[0]), 0);
    goto(14); check("pause rem c14", rem(0), 2);
    goto(15);
    pause = 1'b0;
    first_exp = -1;
    for (int i = 0; i < 16; i++) begin
      if (bus.expire[0] && first_exp < 0) first_exp = cyc;
      cycle();
    end
    check("pause expire cycle", 32'(first_exp), 22);
`else
    first_exp = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
